lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 lsu SHALL have these ports, clock and reset first: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous and active-low.
REQ-003 hs_ex4mem_val  in  1  request valid from exu; hs_mem4ex_rdy  out  1  lsu can accept a request.
REQ-004 i_mem_adr  in  32  byte address; i_mem_d  in  32  store data, LSB-aligned.
REQ-005 i_mem_ren  in  1  load; i_mem_wen  in  1  store.
REQ-006 i_mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal; i_mem_sext  in  1  sign-extend load; i_rd_idx  in  5  load destination register.
REQ-007 o_bus_req  out  1; i_bus_gnt  in  1; o_bus_adr  out  32  word-aligned; o_bus_we  out  1; o_bus_be  out  4; o_bus_wdata  out  32.
REQ-008 i_bus_rvalid  in  1; i_bus_rdata  in  32.
REQ-009 o_rd_wen  out  1; o_rd_idx  out  5; o_rd  out  32  load writeback.
REQ-010 o_misalign  out  1  error pulse; o_misalign_adr  out  32  faulting address.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT_R; hs_mem4ex_rdy = 1 only in IDLE.
REQ-012 Accept when hs_ex4mem_val & hs_mem4ex_rdy; all request fields SHALL be registered on accept.
REQ-013 Accepted request with ren=0 and wen=0: no-op, stay IDLE, no outputs change.
REQ-014 ren=1 and wen=1 together: SHALL execute as a store.
REQ-015 Misaligned (half with adr[0]=1, word with adr[1:0]!=0, or size=11): no bus access, o_misalign=1 and o_misalign_adr=adr for exactly the cycle after accept, stay IDLE.
REQ-016 Aligned access: IDLE->REQ; o_bus_req=1 from cycle after accept; o_bus_adr={adr[31:2],2'b00}, o_bus_we, o_bus_be and o_bus_wdata SHALL be held stable until i_bus_gnt.
REQ-017 Byte enables: byte 4'b0001<<adr[1:0]; half 4'b0011<<adr[1:0]; word 4'b1111.
REQ-018 Store data: byte replicated x4, half replicated x2, word as is.
REQ-019 REQ with gnt: o_bus_req drops next cycle; store -> IDLE; load -> WAIT_R.
REQ-020 i_bus_rvalid SHALL be honoured only in WAIT_R, earliest the cycle after gnt; ignored otherwise.
REQ-021 WAIT_R with rvalid: rdata>>(8*adr[1:0]) then masked to size, zero- or sign-extended per i_mem_sext (word ignores sext); o_rd registered; o_rd_wen=1 for exactly the next cycle with o_rd_idx; state -> IDLE.
REQ-022 Load with rd_idx=0: bus access performed, o_rd_wen SHALL stay 0.
REQ-023 Min latency: store accept T, req T+1, gnt T+1 -> rdy T+2; load rvalid T+2 -> o_rd_wen T+3, rdy T+3.
REQ-024 New request MAY be accepted in the same cycle o_rd_wen or o_misalign is high.
REQ-025 No timeout; lsu waits indefinitely for gnt/rvalid.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and all outputs to 0 (hs_mem4ex_rdy=1 once rst_n=1), from any state including REQ/WAIT_R.
REQ-027 Bus responses to a request interrupted by reset SHALL be ignored.

Structure
REQ-028 Size encodings, FSM state encodings and byte-enable constants SHALL live in the shared cirno9 define header.
REQ-029 One combinational sub-module lsu_align (byte-enable, store replication, load extract/extend) is natural; FSM stays in lsu.

Verification
REQ-030 Store word adr 0x100, d 0xDEADBEEF, gnt immediate -> bus_adr 0x100, be 4'hF, wdata 0xDEADBEEF, we=1, req one cycle.
REQ-031 Load byte sext adr 0x103, rdata 0x80FF_0000, rvalid 3 cycles after gnt -> o_rd 0xFFFFFF80, o_rd_wen one cycle, rd_idx matches.
REQ-032 Store half adr 0x202, d 0x0000_1234, gnt held off 4 cycles -> be 4'b1100, wdata 0x12341234 stable throughout, rdy=0 until gnt+1.
REQ-033 Load word adr 0x105 -> o_misalign=1 one cycle, o_misalign_adr 0x105, no bus_req.
REQ-034 Reset asserted in WAIT_R, then stray rvalid -> IDLE, o_rd_wen stays 0.
REQ-035 Load half zero-ext adr 0x302 rd_idx 0, rdata 0xABCD_0000 -> bus read performed, o_rd_wen never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-enable constants, plus the alignment rule used on accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzIll  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StWaitR = 2'b10
  } lsu_state_e;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Illegal size encoding is reported as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    case (mem_size_e'(size))
      SzByte:  return 1'b0;
      SzHalf:  return off[0];
      SzWord:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication and load
// extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rd_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    be_o    = BeWord;
    wdata_o = wdata_i;
    rd_o    = shifted;
    case (mem_size_e'(size_i))
      SzByte: begin
        be_o    = BeByte << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rd_o    = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      end
      SzHalf: begin
        be_o    = BeHalf << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rd_o    = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time from the execute stage and
// runs it as a single req/gnt(/rvalid) transaction on the data bus.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ex4mem_val,
  output logic        hs_mem4ex_rdy,
  input  logic [31:0] i_mem_adr,
  input  logic [31:0] i_mem_d,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_sext,
  input  logic [4:0]  i_rd_idx,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [31:0] o_bus_adr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_idx,
  output logic [31:0] o_rd,
  output logic        o_misalign,
  output logic [31:0] o_misalign_adr
);

  lsu_state_e  state_q, state_d;
  logic [31:0] adr_q, d_q;
  logic [1:0]  size_q;
  logic        sext_q, we_q;
  logic [4:0]  rd_idx_q;
  logic [31:0] rd_q, misalign_adr_q;
  logic        rd_wen_q, misalign_q;
  logic [4:0]  rd_idx_out_q;

  logic        accept, access, mis, done;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rd_data;

  lsu_align u_align (
    .size_i  (size_q),
    .off_i   (adr_q[1:0]),
    .sext_i  (sext_q),
    .wdata_i (d_q),
    .rdata_i (i_bus_rdata),
    .be_o    (be),
    .wdata_o (wdata_rep),
    .rd_o    (rd_data)
  );

  // Not ready while reset is held so nothing is accepted across reset release.
  assign hs_mem4ex_rdy = (state_q == StIdle) & rst_n;

  always_comb begin
    accept  = hs_ex4mem_val & hs_mem4ex_rdy;
    access  = accept & (i_mem_ren | i_mem_wen);
    mis     = access & is_misaligned(i_mem_size, i_mem_adr[1:0]);
    done    = (state_q == StWaitR) & i_bus_rvalid;
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (access && !mis) state_d = StReq;
      StReq:   if (i_bus_gnt) state_d = we_q ? StIdle : StWaitR;
      StWaitR: if (i_bus_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_bus_req   = (state_q == StReq);
    o_bus_adr   = '0;
    o_bus_we    = 1'b0;
    o_bus_be    = '0;
    o_bus_wdata = '0;
    if (o_bus_req) begin
      o_bus_adr   = {adr_q[31:2], 2'b00};
      o_bus_we    = we_q;
      o_bus_be    = be;
      o_bus_wdata = wdata_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      adr_q          <= '0;
      d_q            <= '0;
      size_q         <= '0;
      sext_q         <= 1'b0;
      we_q           <= 1'b0;
      rd_idx_q       <= '0;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      rd_idx_out_q   <= '0;
      misalign_q     <= 1'b0;
      misalign_adr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q    <= i_mem_adr;
        d_q      <= i_mem_d;
        size_q   <= i_mem_size;
        sext_q   <= i_mem_sext;
        we_q     <= i_mem_wen;
        rd_idx_q <= i_rd_idx;
      end
      misalign_q     <= mis;
      misalign_adr_q <= mis ? i_mem_adr : '0;
      // x0 loads still touch the bus but never write back.
      rd_wen_q       <= done & (rd_idx_q != 5'd0);
      if (done) begin
        rd_q         <= rd_data;
        rd_idx_out_q <= rd_idx_q;
      end
    end
  end

  assign o_rd_wen       = rd_wen_q;
  assign o_rd_idx       = rd_idx_out_q;
  assign o_rd           = rd_q;
  assign o_misalign     = misalign_q;
  assign o_misalign_adr = misalign_adr_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// transactions against a behavioural model of the access rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_ex4mem_val, hs_mem4ex_rdy;
  logic [31:0] i_mem_adr, i_mem_d;
  logic        i_mem_ren, i_mem_wen, i_mem_sext;
  logic [1:0]  i_mem_size;
  logic [4:0]  i_rd_idx;
  logic        o_bus_req, i_bus_gnt, o_bus_we;
  logic [31:0] o_bus_adr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        o_rd_wen;
  logic [4:0]  o_rd_idx;
  logic [31:0] o_rd;
  logic        o_misalign;
  logic [31:0] o_misalign_adr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hs_ex4mem_val  (hs_ex4mem_val),
    .hs_mem4ex_rdy  (hs_mem4ex_rdy),
    .i_mem_adr      (i_mem_adr),
    .i_mem_d        (i_mem_d),
    .i_mem_ren      (i_mem_ren),
    .i_mem_wen      (i_mem_wen),
    .i_mem_size     (i_mem_size),
    .i_mem_sext     (i_mem_sext),
    .i_rd_idx       (i_rd_idx),
    .o_bus_req      (o_bus_req),
    .i_bus_gnt      (i_bus_gnt),
    .o_bus_adr      (o_bus_adr),
    .o_bus_we       (o_bus_we),
    .o_bus_be       (o_bus_be),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_rvalid   (i_bus_rvalid),
    .i_bus_rdata    (i_bus_rdata),
    .o_rd_wen       (o_rd_wen),
    .o_rd_idx       (o_rd_idx),
    .o_rd           (o_rd),
    .o_misalign     (o_misalign),
    .o_misalign_adr (o_misalign_adr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access rules stated as plain arithmetic.
  function automatic bit m_misaligned(logic [31:0] adr, logic [1:0] size);
    int nbytes;
    if (size == 2'd3) return 1'b1;
    nbytes = 1 << size;
    return (adr % nbytes) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [31:0] adr, logic [1:0] size);
    int nbytes;
    int mask;
    nbytes = 1 << size;
    mask = ((1 << nbytes) - 1) << (adr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d, logic [1:0] size);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] rdata, logic [31:0] adr, logic [1:0] size,
                                         logic sext);
    int nbits;
    logic [63:0] v;
    nbits = 8 << size;
    v = 64'(rdata) / (64'd1 << (8 * (adr % 4)));
    if (nbits < 32) begin
      v = v % (64'd1 << nbits);
      if (sext && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
    end
    return v[31:0];
  endfunction

  // Runs one request starting at a negedge; returns at the negedge where the
  // result is visible so the next call overlaps acceptance with it.
  task automatic do_txn(input logic [31:0] adr, input logic [31:0] d, input logic ren,
                        input logic wen, input logic [1:0] size, input logic sext,
                        input logic [4:0] idx, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly);
    bit is_load;
    is_load = ren && !wen;
    check_eq("rdy_before", 32'(hs_mem4ex_rdy), 32'd1);
    hs_ex4mem_val = 1'b1;
    i_mem_adr = adr; i_mem_d = d; i_mem_ren = ren; i_mem_wen = wen;
    i_mem_size = size; i_mem_sext = sext; i_rd_idx = idx;
    @(negedge clk);
    hs_ex4mem_val = 1'b0;
    i_mem_adr = $urandom; i_mem_d = $urandom; i_mem_size = 2'($urandom);
    i_mem_sext = 1'($urandom); i_rd_idx = 5'($urandom);
    i_mem_ren = 1'($urandom); i_mem_wen = 1'($urandom);
    if (!ren && !wen) begin
      check_eq("noop_rdy", 32'(hs_mem4ex_rdy), 32'd1);
      check_eq("noop_req", 32'(o_bus_req), 32'd0);
      check_eq("noop_mis", 32'(o_misalign), 32'd0);
      check_eq("noop_rdwen", 32'(o_rd_wen), 32'd0);
    end else if (m_misaligned(adr, size)) begin
      check_eq("mis_flag", 32'(o_misalign), 32'd1);
      check_eq("mis_adr", o_misalign_adr, adr);
      check_eq("mis_req", 32'(o_bus_req), 32'd0);
      check_eq("mis_rdy", 32'(hs_mem4ex_rdy), 32'd1);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq("req", 32'(o_bus_req), 32'd1);
        check_eq("req_adr", o_bus_adr, adr - (adr % 4));
        check_eq("req_we", 32'(o_bus_we), 32'(wen));
        check_eq("req_be", 32'(o_bus_be), 32'(m_be(adr, size)));
        if (wen) check_eq("req_wdata", o_bus_wdata, m_wdata(d, size));
        check_eq("req_rdy", 32'(hs_mem4ex_rdy), 32'd0);
        check_eq("req_rdwen", 32'(o_rd_wen), 32'd0);
        check_eq("req_mis", 32'(o_misalign), 32'd0);
        i_bus_gnt = (i == gnt_dly);
        i_bus_rvalid = 1'($urandom);
        i_bus_rdata = $urandom;
        @(negedge clk);
      end
      i_bus_gnt = 1'b0;
      i_bus_rvalid = 1'b0;
      check_eq("post_gnt_req", 32'(o_bus_req), 32'd0);
      if (!is_load) begin
        check_eq("st_rdy", 32'(hs_mem4ex_rdy), 32'd1);
      end else begin
        for (int i = 0; i <= rv_dly; i++) begin
          check_eq("wr_rdy", 32'(hs_mem4ex_rdy), 32'd0);
          check_eq("wr_rdwen", 32'(o_rd_wen), 32'd0);
          i_bus_rvalid = (i == rv_dly);
          i_bus_rdata = (i == rv_dly) ? rdata : $urandom;
          @(negedge clk);
        end
        i_bus_rvalid = 1'b0;
        i_bus_rdata = $urandom;
        check_eq("ld_rdy", 32'(hs_mem4ex_rdy), 32'd1);
        check_eq("ld_rdwen", 32'(o_rd_wen), 32'(idx != 5'd0));
        if (idx != 5'd0) begin
          check_eq("ld_rd", o_rd, m_load(rdata, adr, size, sext));
          check_eq("ld_idx", 32'(o_rd_idx), 32'(idx));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, d;
    logic [1:0]  size;
    int          op;
    rst_n = 1'b0;
    hs_ex4mem_val = 1'b0;
    i_mem_adr = '0; i_mem_d = '0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
    i_mem_size = '0; i_mem_sext = 1'b0; i_rd_idx = '0;
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", 32'(hs_mem4ex_rdy), 32'd0);
    check_eq("rst_req", 32'(o_bus_req), 32'd0);
    check_eq("rst_adr", o_bus_adr, 32'd0);
    check_eq("rst_rdwen", 32'(o_rd_wen), 32'd0);
    check_eq("rst_rd", o_rd, 32'd0);
    check_eq("rst_mis", 32'(o_misalign), 32'd0);
    check_eq("rst_misadr", o_misalign_adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_rdy", 32'(hs_mem4ex_rdy), 32'd1);

    // Directed scenarios.
    do_txn(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'h0, 0, 0);
    do_txn(32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd9, 32'h80FF_0000, 0, 2);
    do_txn(32'h202, 32'h0000_1234, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 32'h0, 4, 0);
    do_txn(32'h105, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd3, 32'h0, 0, 0);
    do_txn(32'h302, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 32'hABCD_0000, 1, 1);
    do_txn(32'h301, 32'h55AA_77CC, 1'b1, 1'b1, 2'd0, 1'b1, 5'd4, 32'h0, 0, 0);

    // Reset while waiting for read data; later rvalid must be ignored.
    @(negedge clk);
    hs_ex4mem_val = 1'b1; i_mem_adr = 32'h400; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
    i_mem_size = 2'd2; i_rd_idx = 5'd7;
    @(negedge clk);
    hs_ex4mem_val = 1'b0;
    i_bus_gnt = 1'b1;
    @(negedge clk);
    i_bus_gnt = 1'b0;
    check_eq("wr_rst_pre_rdy", 32'(hs_mem4ex_rdy), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("wr_rst_req", 32'(o_bus_req), 32'd0);
    check_eq("wr_rst_rdwen", 32'(o_rd_wen), 32'd0);
    rst_n = 1'b1;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("wr_rst_rdy", 32'(hs_mem4ex_rdy), 32'd1);
    check_eq("wr_rst_rdwen1", 32'(o_rd_wen), 32'd0);
    @(negedge clk);
    i_bus_rvalid = 1'b0;
    check_eq("wr_rst_rdwen2", 32'(o_rd_wen), 32'd0);

    // Reset while requesting; a late grant must be ignored.
    hs_ex4mem_val = 1'b1; i_mem_adr = 32'h500; i_mem_ren = 1'b0; i_mem_wen = 1'b1;
    i_mem_size = 2'd2;
    @(negedge clk);
    hs_ex4mem_val = 1'b0;
    check_eq("rq_rst_pre_req", 32'(o_bus_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rq_rst_req", 32'(o_bus_req), 32'd0);
    check_eq("rq_rst_adr", o_bus_adr, 32'd0);
    rst_n = 1'b1;
    i_bus_gnt = 1'b1;
    @(negedge clk);
    i_bus_gnt = 1'b0;
    check_eq("rq_rst_rdy", 32'(hs_mem4ex_rdy), 32'd1);
    check_eq("rq_rst_req2", 32'(o_bus_req), 32'd0);

    // Randomized transactions, back to back.
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      size = 2'($urandom_range(0, 3));
      adr = $urandom;
      if ($urandom_range(0, 1) == 0 && size != 2'd3) adr = adr - (adr % (1 << size));
      d = $urandom;
      do_txn(adr, d, (op >= 1 && op <= 4) || op == 9, op >= 5, size, 1'($urandom),
             ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
